uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single RS232 transmitter between NUM_REQ independent byte sources.
//  Round-robin arbitration per packet: a grantee keeps the transmitter until it sends a byte with req_last=1.
//  Sequences the transmitter's start_TX/TX_ready handshake and flags stalls.
//  Sits between the CPU/debug byte producers and the UART core.
// PARAMETERS
//  NUM_REQ       4        number of requesters (2..8)
//  IDW           2        width of grant_id, >= clog2(NUM_REQ)
//  ACK_TIMEOUT   16       max cycles for uart_tx_ready to fall after a start pulse
//  LOCK_TIMEOUT  50000000 max idle cycles a locked grantee may stall mid-packet (1 s)
// PORTS
//  clk            in   1          system clock, 50 MHz
//  rst            in   1          asynchronous reset, active-low
//  req_valid      in   NUM_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data       in   8*NUM_REQ  byte per requester
//  req_last       in   NUM_REQ    byte is last of packet; releases the grant
//  req_ready      out  NUM_REQ    one-cycle accept strobe; byte consumed when valid&ready
//  uart_tx        out  8          byte to UART TX input
//  uart_start_tx  out  1          one-cycle start pulse to UART
//  uart_tx_ready  in   1          UART transmitter idle
//  grant_id       out  IDW        current/last grantee index
//  busy           out  1          high in every state except IDLE
//  timeout_err    out  1          one-cycle pulse on ack or lock timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant_id=0, locked=0; all outputs 0 (uart_tx=8'h00).
//  Reset mid-byte: arbiter returns to IDLE; a byte already in the UART completes independently.
//  States:
//  - IDLE: if locked, eligible set = {grant_id}; else all i. Wait for uart_tx_ready=1 and an eligible valid.
//    Pick first valid at/after rr_ptr (wrapping); latch grant_id; -> SEND next cycle.
//  - SEND (exactly 1 cycle): uart_start_tx=1, uart_tx=req_data[grant_id], req_ready[grant_id]=1.
//    locked <= ~req_last[grant_id]. -> WAIT_LO.
//  - WAIT_LO: wait uart_tx_ready=0 -> WAIT_HI.
//    ACK_TIMEOUT cycles without the fall: timeout_err pulse, locked=0, -> IDLE.
//  - WAIT_HI: wait uart_tx_ready=1 (byte, incl. stop bit, done).
//    If locked -> IDLE (grantee only eligible). Else rr_ptr <= grant_id+1 mod NUM_REQ, -> IDLE.
//  - No timeout in WAIT_HI; one 9600-baud frame is ~52k cycles.
//  Lock stall: in IDLE with locked=1 and req_valid[grant_id]=0, count cycles.
//    At LOCK_TIMEOUT: timeout_err pulse, locked=0, rr_ptr <= grant_id+1.
//  Counters clear on every state change; the lock counter also clears on each accepted byte.
//  Latency: eligible valid in IDLE at cycle t (UART ready) -> uart_start_tx at t+1.
//    Back-to-back bytes are gated only by UART frame time plus 2 cycles.
//  req_ready is high only in SEND. Requesters must hold valid/data/last stable until accepted.
//  Dropping valid before accept while unlocked: request withdrawn; no byte sent.
//  Invalid state encoding: -> IDLE.
//  uart_tx holds its last value outside SEND; the UART samples it only on start.
//  Simultaneous valid from all requesters with rr_ptr=k: k wins; next unlocked grant goes to k+1.
// TESTING
//  1. Reset, req 2 sends 8'hA5 last=1 -> one start pulse, uart_tx=A5, req_ready[2] for 1 cycle, rr_ptr=3.
//  2. All 4 valid, last=1, continuous -> grant order 0,1,2,3,0; one start per frame; no overlap.
//  3. Req 1 sends 3-byte packet (last on 3rd); req 0 valid throughout -> bytes 1,1,1 then 0.
//  4. Req 3 locked, then drops valid; LOCK_TIMEOUT=100 -> timeout_err at cycle 100; req 0 granted next.
//  5. UART model never drops tx_ready -> timeout_err ACK_TIMEOUT cycles after start; back in IDLE; locked=0.
//  6. Assert rst during WAIT_HI -> all outputs 0 same cycle; after release, a new request is served from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte sources. Grants are
// round-robin per packet: the grantee stays locked until it sends a byte
// marked req_last. The block drives the UART start/ready handshake and
// raises a one-cycle timeout_err if the UART never acknowledges a start
// or if a locked grantee stalls too long between bytes.
//
// Timeout timing:
//  - ack timeout: timeout_err is high exactly ACK_TIMEOUT cycles after the
//    uart_start_tx cycle, provided uart_tx_ready never fell in between.
//  - lock timeout: counting the first stalled IDLE cycle as cycle 1,
//    timeout_err is high on stalled cycle LOCK_TIMEOUT. The lock is already
//    released in that cycle, so another requester can win it.
// Both timeouts must be at least 2.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDW          = 2,
    parameter int ACK_TIMEOUT  = 16,
    parameter int LOCK_TIMEOUT = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_tx,
    output logic                   uart_start_tx,
    input  logic                   uart_tx_ready,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int ACW = $clog2(ACK_TIMEOUT + 1);
    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);

    // The SEND cycle and the first counted cycle are both part of the
    // timeout window, and the registered pulse adds one more, hence -2.
    localparam logic [ACW-1:0] ACK_LIMIT  = ACW'(ACK_TIMEOUT - 2);
    localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(LOCK_TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_WAIT_HI = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic                 locked_q, locked_d;
    logic [ACW-1:0]       ack_cnt_q, ack_cnt_d;
    logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [7:0]           uart_tx_q, uart_tx_d;
    logic                 start_q, start_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 pick_found_s;
    logic [IDW-1:0]       pick_id_s;

    // (base + off) modulo NUM_REQ, for base and off both below NUM_REQ.
    function automatic logic [IDW-1:0] rr_wrap(input logic [IDW-1:0] base,
                                               input logic [IDW-1:0] off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    // Arbitration: a locked grantee is the only candidate; otherwise pick the first valid requester at or after rr_ptr.
    always_comb begin
        logic [IDW-1:0] idx_v;
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        idx_v        = '0;
        if (locked_q) begin
            if (req_valid[grant_id_q]) begin
                pick_found_s = 1'b1;
                pick_id_s    = grant_id_q;
            end else begin
                pick_found_s = 1'b0;
            end
        end else begin
            // Scan from the farthest offset down so the nearest valid one wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx_v = rr_wrap(rr_ptr_q, IDW'(k));
                if (req_valid[idx_v]) begin
                    pick_found_s = 1'b1;
                    pick_id_s    = idx_v;
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Next-state logic: handshake sequencing, lock tracking, timeouts and rr_ptr update.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        locked_d      = locked_q;
        ack_cnt_d     = ack_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (uart_tx_ready && pick_found_s) begin
                    grant_id_d = pick_id_s;
                    state_d    = ST_SEND;
                end else if (locked_q && !req_valid[grant_id_q]) begin
                    // Locked grantee has nothing to send: count the stall.
                    if (lock_cnt_q >= LOCK_LIMIT) begin
                        timeout_err_d = 1'b1;
                        locked_d      = 1'b0;
                        rr_ptr_d      = rr_wrap(grant_id_q, IDW'(1));
                        lock_cnt_d    = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end
            ST_SEND: begin
                // Byte is accepted this cycle; its last flag decides the lock.
                locked_d   = ~req_last[grant_id_q];
                lock_cnt_d = '0;
                state_d    = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!uart_tx_ready) begin
                    state_d = ST_WAIT_HI;
                end else if (ack_cnt_q >= ACK_LIMIT) begin
                    timeout_err_d = 1'b1;
                    locked_d      = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACW'(1);
                end
            end
            ST_WAIT_HI: begin
                // No timeout here: a slow-baud frame legitimately takes ~52k cycles.
                if (uart_tx_ready) begin
                    state_d = ST_IDLE;
                    if (!locked_q) begin
                        rr_ptr_d = rr_wrap(grant_id_q, IDW'(1));
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            ack_cnt_d  = '0;
            lock_cnt_d = '0;
        end else begin
            ack_cnt_d  = ack_cnt_d;
        end
    end

    // Output next values: the strobes are set on entry to SEND so they are high exactly while in SEND.
    always_comb begin
        start_d     = (state_d == ST_SEND);
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = '0;
        uart_tx_d   = uart_tx_q;
        if (start_d) begin
            req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_d;
            uart_tx_d   = req_data[32'(grant_id_d) * 32'd8 +: 8];
        end else begin
            req_ready_d = '0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            locked_q      <= 1'b0;
            ack_cnt_q     <= '0;
            lock_cnt_q    <= '0;
            uart_tx_q     <= 8'h00;
            start_q       <= 1'b0;
            req_ready_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            locked_q      <= locked_d;
            ack_cnt_q     <= ack_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            uart_tx_q     <= uart_tx_d;
            start_q       <= start_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign uart_tx       = uart_tx_q;
    assign uart_start_tx = start_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester byte sources, a UART model,
// and a scoreboard of expected (grantee, byte) pairs checked on each start.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data  = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N-1:0]    req_ready;
    logic [7:0]      uart_tx;
    logic            uart_start_tx;
    logic            uart_tx_ready = 1'b1;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [8:0] src_mem [N][16];
    int         src_wr  [N];
    int         src_rd  [N];
    logic [N-1:0] drv_acc;

    logic uart_dead = 1'b0;
    int   frame_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ(N), .IDW(2), .ACK_TIMEOUT(16), .LOCK_TIMEOUT(100)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx(uart_tx), .uart_start_tx(uart_start_tx),
        .uart_tx_ready(uart_tx_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic src_push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_wr[r]] = {l, d};
        src_wr[r]++;
    endtask

    task automatic exp_push(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic srcs_empty();
        logic e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] != src_wr[i]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && uart_tx_ready && srcs_empty()) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (uart_start_tx !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_start"}, 32'(uart_start_tx), 32'd0);
        chk({tag, "_tx"},    32'(uart_tx),       32'd0);
        chk({tag, "_ready"}, 32'(req_ready),     32'd0);
        chk({tag, "_grant"}, 32'(grant_id),      32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_to"},    32'(timeout_err),   32'd0);
    endtask

    // Requester sources: retire a byte after its accept edge, then present the next one.
    always @(posedge clk) begin
        drv_acc = req_valid & req_ready;
        #1;
        for (int i = 0; i < N; i++) begin
            if (drv_acc[i]) src_rd[i]++;
            if (src_rd[i] != src_wr[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = src_mem[i][src_rd[i]][7:0];
                req_last[i]         = src_mem[i][src_rd[i]][8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // UART model: a start drops ready for FRAME cycles; a dead UART ignores starts.
    always @(posedge clk) begin
        #1;
        if (uart_start_tx === 1'b1 && !uart_dead) begin
            uart_tx_ready = 1'b0;
            frame_cnt     = FRAME;
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) uart_tx_ready = 1'b1;
        end
    end

    // Scoreboard monitor: every start pulse must match the next expected grant and byte.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (uart_start_tx === 1'b1) begin
                chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte",   32'(uart_tx),   32'(mon_e.data));
                    chk("grant_id",  32'(grant_id),  32'(mon_e.id));
                    chk("req_ready", 32'(req_ready), 32'(4'b0001 << mon_e.id));
                end
            end else if (req_ready !== 4'b0000) begin
                chk("ready_no_start", 32'(req_ready), 32'd0);
            end
        end
    end

    initial begin
        int n;
        int m;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // 1: single byte from req 2, then rr_ptr=3 means 3 beats 0.
        src_push(2, 8'hA5, 1'b1);
        exp_push(2'd2, 8'hA5);
        wait_idle("t1_idle");
        src_push(0, 8'h11, 1'b1);
        src_push(3, 8'h33, 1'b1);
        exp_push(2'd3, 8'h33);
        exp_push(2'd0, 8'h11);
        wait_idle("t1b_idle");

        // 2: after reset, all four valid -> 0,1,2,3,0.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        src_push(0, 8'h20, 1'b1);
        src_push(0, 8'h24, 1'b1);
        src_push(1, 8'h21, 1'b1);
        src_push(2, 8'h22, 1'b1);
        src_push(3, 8'h23, 1'b1);
        exp_push(2'd0, 8'h20);
        exp_push(2'd1, 8'h21);
        exp_push(2'd2, 8'h22);
        exp_push(2'd3, 8'h23);
        exp_push(2'd0, 8'h24);
        wait_idle("t2_idle");

        // 3: rr_ptr=1; req 1 three-byte packet holds the lock over req 0.
        src_push(1, 8'h31, 1'b0);
        src_push(1, 8'h32, 1'b0);
        src_push(1, 8'h33, 1'b1);
        src_push(0, 8'h30, 1'b1);
        exp_push(2'd1, 8'h31);
        exp_push(2'd1, 8'h32);
        exp_push(2'd1, 8'h33);
        exp_push(2'd0, 8'h30);
        wait_idle("t3_idle");

        // 4: rr_ptr=1; req 3 locks then goes silent, req 0 waits for the lock timeout.
        src_push(3, 8'hC3, 1'b0);
        src_push(0, 8'h0D, 1'b1);
        exp_push(2'd3, 8'hC3);
        exp_push(2'd0, 8'h0D);
        n = 0;
        while (exp_q.size() != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_c3_sent", 32'(n < 200), 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_back_idle", 32'(n < 200), 32'd1);
        n = 1;
        while (timeout_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t4_lock_to_cycle", 32'(n), 32'd100);
        m = n;
        while (uart_start_tx !== 1'b1 && m < n + 10) begin
            @(negedge clk);
            m++;
        end
        chk("t4_next_start", 32'(m), 32'd101);
        wait_idle("t4_idle");

        // 5: UART never acknowledges; byte would lock (last=0) but the timeout clears it.
        uart_dead = 1'b1;
        src_push(2, 8'hE2, 1'b0);
        exp_push(2'd2, 8'hE2);
        wait_start("t5_start");
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ack_to_cycles", 32'(n), 32'd16);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t5_pulse_width", 32'(timeout_err), 32'd0);
        uart_dead = 1'b0;
        src_push(1, 8'h51, 1'b1);
        exp_push(2'd1, 8'h51);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (uart_start_tx === 1'b1) break;
        end
        chk("t5_unlocked_latency", 32'(n), 32'd2);
        wait_idle("t5_idle");

        // 6: reset during WAIT_HI clears outputs at once; service restarts from rr_ptr=0.
        src_push(1, 8'h61, 1'b1);
        exp_push(2'd1, 8'h61);
        wait_start("t6_start");
        repeat (3) @(negedge clk);
        chk("t6_busy_wait_hi", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        src_push(3, 8'h73, 1'b1);
        src_push(1, 8'h71, 1'b1);
        exp_push(2'd1, 8'h71);
        exp_push(2'd3, 8'h73);
        wait_idle("t6_idle");
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
